// File: rtl/alu_pkg.sv
// Shared constants for the ALU dispatch path.
// Channel count, select width, state encoding.
package alu_pkg;

  localparam int CH_N    = 16;
  localparam int SEL_W   = 4;
  localparam int TMO_DEF = 255;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/dec4to16.sv
// Enable-gated 4-to-16 one-hot decoder.
// All outputs are zero when en_i is low.
module dec4to16
  import alu_pkg::*;
(
  input  logic             en_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [CH_N-1:0]  oh_o
);

  always_comb begin
    oh_o = '0;
    if (en_i) oh_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/demux16to1_dispatch.sv
// One-entry registered 1-to-16 dispatcher with
// stall watchdog and transfer counter.
module demux16to1_dispatch
  import alu_pkg::*;
#(
  parameter int w   = 64,
  parameter int TMO = TMO_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [w-1:0]     in_data,
  input  logic [SEL_W-1:0] in_sel,
  output logic [CH_N-1:0]  out_valid,
  input  logic [CH_N-1:0]  out_ready,
  output logic [w-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  output logic             stall_err,
  input  logic             err_clr,
  output logic [31:0]      xfer_cnt
);

  localparam logic [15:0] TMO_C = 16'(TMO);

  state_e           state_q, state_d;
  logic [w-1:0]     data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [15:0]      wait_q, wait_d;
  logic             err_q, err_d;
  logic [31:0]      xfer_q, xfer_d;

  logic [CH_N-1:0]  sel_oh;
  logic             full, acc, in_xfer, stalled;

  assign full = (state_q == ST_FULL);

  dec4to16 u_vld (
    .en_i  (full),
    .sel_i (sel_q),
    .oh_o  (out_valid)
  );

  dec4to16 u_rdy (
    .en_i  (1'b1),
    .sel_i (sel_q),
    .oh_o  (sel_oh)
  );

  assign acc     = full && |(out_ready & sel_oh);
  assign in_ready = !full || acc;
  assign in_xfer = in_valid && in_ready;
  assign stalled = full && !acc;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    unique case (state_q)
      ST_EMPTY: if (in_xfer) state_d = ST_FULL;
      ST_FULL:  if (acc && !in_xfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (in_xfer) begin
      data_d = in_data;
      sel_d  = in_sel;
    end
  end

  // Saturating wait counter; set beats clear on the same cycle.
  always_comb begin
    wait_d = '0;
    if (stalled)
      wait_d = (wait_q == TMO_C) ? wait_q : wait_q + 16'd1;
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (stalled && wait_d == TMO_C) err_d = 1'b1;
    xfer_d = acc ? xfer_q + 32'd1 : xfer_q;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      xfer_q  <= xfer_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign stall_err = err_q;
  assign xfer_cnt  = xfer_q;

endmodule

// File: tb/tb_demux16to1_dispatch.sv
// Directed bench for demux16to1_dispatch.
// DUT built with TMO=4 so the watchdog is reachable quickly.
module tb_demux16to1_dispatch;

  logic        clk;
  logic        rst_b;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [3:0]  in_sel;
  logic [15:0] out_valid;
  logic [15:0] out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_sel;
  logic        stall_err;
  logic        err_clr;
  logic [31:0] xfer_cnt;

  int checks = 0;
  int errors = 0;

  demux16to1_dispatch #(.w(64), .TMO(4)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .stall_err (stall_err),
    .err_clr   (err_clr),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_b     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h1234;
    in_sel    = 4'd2;
    out_ready = 16'h0000;
    err_clr   = 1'b0;

    // reset / idle
    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_xfer_cnt", 64'(xfer_cnt), 64'h0);
    chk("rst_stall_err", 64'(stall_err), 64'h0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_sel", 64'(out_sel), 64'h0);
    in_valid = 1'b0;
    rst_b    = 1'b1;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'h1);

    // single beat to channel 5
    step();
    in_valid  = 1'b1;
    in_data   = 64'hDEAD_BEEF_0000_0005;
    in_sel    = 4'd5;
    out_ready = 16'h0020;
    step();
    in_valid = 1'b0;
    chk("single_out_valid", 64'(out_valid), 64'h0020);
    chk("single_out_data", out_data, 64'hDEAD_BEEF_0000_0005);
    chk("single_out_sel", 64'(out_sel), 64'h5);
    chk("single_in_ready", 64'(in_ready), 64'h1);
    step();
    chk("single_empty", 64'(out_valid), 64'h0);
    chk("single_xfer", 64'(xfer_cnt), 64'h1);

    // back-pressure on channel 3
    out_ready = 16'h0000;
    in_valid  = 1'b1;
    in_data   = 64'hAAAA_0000_0000_0003;
    in_sel    = 4'd3;
    step();
    in_data = 64'hBBBB_0000_0000_0001;
    in_sel  = 4'd1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 64'(out_valid), 64'h0008);
      chk("bp_in_ready", 64'(in_ready), 64'h0);
      chk("bp_out_data", out_data, 64'hAAAA_0000_0000_0003);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 16'h0080;
    step();
    chk("bp_wrong_ready", 64'(out_valid), 64'h0008);
    chk("bp_wrong_xfer", 64'(xfer_cnt), 64'h1);
    out_ready = 16'h0008;
    #1;
    chk("bp_comb_ready", 64'(in_ready), 64'h1);
    step();
    chk("bp_done_valid", 64'(out_valid), 64'h0);
    chk("bp_done_xfer", 64'(xfer_cnt), 64'h2);
    chk("bp_stall_seen", 64'(stall_err), 64'h1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("bp_stall_clr", 64'(stall_err), 64'h0);

    // streaming 16 beats, sel 0..15
    out_ready = 16'hFFFF;
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_sel  = 4'(i);
      in_data = 64'h5000 + 64'(i);
      #1;
      chk("str_in_ready", 64'(in_ready), 64'h1);
      step();
      chk("str_out_valid", 64'(out_valid), 64'h1 << i);
      chk("str_out_data", out_data, 64'h5000 + 64'(i));
    end
    in_valid = 1'b0;
    step();
    chk("str_empty", 64'(out_valid), 64'h0);
    // 2 earlier transfers + 16 streamed
    chk("str_xfer", 64'(xfer_cnt), 64'd18);

    // watchdog, TMO=4, channel 9
    out_ready = 16'h0000;
    in_valid  = 1'b1;
    in_sel    = 4'd9;
    in_data   = 64'h9999;
    step();
    in_valid = 1'b0;
    chk("wd_load0", 64'(stall_err), 64'h0);
    step();
    chk("wd_load1", 64'(stall_err), 64'h0);
    step();
    chk("wd_load2", 64'(stall_err), 64'h0);
    step();
    chk("wd_load3", 64'(stall_err), 64'h0);
    step();
    chk("wd_set4", 64'(stall_err), 64'h1);
    chk("wd_held", 64'(out_valid), 64'h0200);
    chk("wd_data", out_data, 64'h9999);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("wd_set_wins", 64'(stall_err), 64'h1);
    out_ready = 16'h0200;
    step();
    chk("wd_acc_valid", 64'(out_valid), 64'h0);
    chk("wd_acc_xfer", 64'(xfer_cnt), 64'd19);
    chk("wd_sticky", 64'(stall_err), 64'h1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("wd_cleared", 64'(stall_err), 64'h0);

    // counter wrap
    force dut.xfer_q = 32'hFFFF_FFFF;
    #1;
    release dut.xfer_q;
    chk("wrap_preload", 64'(xfer_cnt), 64'hFFFF_FFFF);
    in_valid  = 1'b1;
    in_sel    = 4'd0;
    in_data   = 64'h77;
    out_ready = 16'h0001;
    step();
    in_valid = 1'b0;
    step();
    chk("wrap_zero", 64'(xfer_cnt), 64'h0);

    // async reset while FULL
    out_ready = 16'h0000;
    in_valid  = 1'b1;
    in_sel    = 4'd6;
    in_data   = 64'h66;
    step();
    in_valid = 1'b0;
    chk("ar_full", 64'(out_valid), 64'h0040);
    #2;
    rst_b = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'h0);
    chk("ar_in_ready", 64'(in_ready), 64'h1);
    chk("ar_data", out_data, 64'h0);
    #1;
    rst_b = 1'b1;
    step();
    chk("ar_stay_empty", 64'(out_valid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
